gold_pe_port: RTL and testbench
===============================

# gold_pe_port

Router-side endpoint of the processing-element (PE) interface for the gold ring router. It sources the `polarity` phase signal to the PE, accepts injected packets on `pesi/peri/pedi` into per-virtual-channel (VC) injection buffers, and hands them to the router core on the matching phase. In the other direction it buffers packets ejected by the router core and presents them to the PE on `peso/pero/pedo`. One instance sits inside each `gold_router`, between the PE pins and the router's ring arbitration logic.

## Interface
- `DW`, 64: packet width; bit `DW-1` is the VC bit (0 = EVEN, 1 = ODD).
- `CW`, 16: width of the injection and ejection packet counters.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `polarity`  out  1  phase to the PE; 0 = EVEN, 1 = ODD.
- `pesi`  in  1  PE send valid.
- `peri`  out  1  port ready to accept a PE packet.
- `pedi`  in  DW  PE send data.
- `peso`  out  1  packet valid to the PE (registered).
- `pero`  in  1  PE ready to take a packet.
- `pedo`  out  DW  packet to the PE (registered).
- `inj_valid`  out  1  injection packet offered to the router core.
- `inj_ready`  in  1  router core accepts the offered packet.
- `inj_data`  out  DW  offered packet.
- `ej_valid`  in  1  router core has a packet for the local PE.
- `ej_data`  in  DW  that packet; VC given by `ej_data[DW-1]`.
- `ej_ready`  out  2  per-VC ejection buffer not full; bit v = VC v.
- `err_vc`  out  1  sticky VC-mismatch flag.
- `inj_cnt`  out  CW  packets accepted from the PE.
- `ej_cnt`  out  CW  packets delivered to the PE.

## Operation
- Reset (`reset` = 0, asynchronous):
  - `polarity` = 0.
  - Both injection and both ejection buffers are empty.
  - `peso` = 0, `pedo` = 0, `err_vc` = 0, `inj_cnt` = 0, `ej_cnt` = 0.
  - A reset asserted mid-operation discards all buffered packets immediately.
- Polarity: toggles on every rising edge after reset is released. The first cycle after release is EVEN.
- Injection buffers: one single-entry buffer per VC (`inj_full[1:0]`, `inj_buf[1:0]`).
  - A packet the PE presents while `polarity` = P belongs to VC ~P.
  - `peri` = ~`inj_full[~polarity]` (combinational).
  - Accept when `pesi` & `peri`: write `pedi` into VC ~P, set `inj_full[~P]`, increment `inj_cnt` (wraps at 2^CW).
  - If `pedi[DW-1]` != ~P: the packet is dropped, `err_vc` is set (sticky until reset), and `inj_cnt` is not incremented.
  - `pesi` while `peri` = 0 is ignored. There is no error and no state change.
- Drain to the router core:
  - `inj_valid` = `inj_full[polarity]`; `inj_data` = `inj_buf[polarity]`.
  - A transfer occurs on an edge where `inj_valid` & `inj_ready`; it clears `inj_full[polarity]`.
  - Accept and drain never target the same VC in the same cycle, so the two need no arbitration.
- Ejection buffers: one single-entry buffer per VC.
  - `ej_ready[v]` = ~`ej_full[v]`.
  - On `ej_valid` with `ej_ready[ej_data[DW-1]]` = 1, the packet is written into that VC's buffer.
  - The router core must not assert `ej_valid` to a full VC. If it does, the packet is ignored and the buffer contents are preserved.
- Delivery to the PE:
  - On each edge, if `pero` & `ej_full[polarity]`: `peso` <= 1, `pedo` <= that buffer's contents, the buffer is cleared, and `ej_cnt` increments.
  - Otherwise `peso` <= 0 and `pedo` <= 0.
- Simultaneous write and delivery on the same VC in one cycle cannot occur, because a write requires the buffer to be empty. The new packet is delivered no earlier than the next matching phase.
- Packet contents are never modified. Hop count, direction and source/destination fields pass through untouched.

## Timing
- Injection: the edge that accepts a packet in VC v is followed by a cycle where `polarity` = v, so `inj_valid` rises in the cycle immediately after acceptance. Minimum PE-to-core latency is 1 cycle.
- If `inj_ready` = 0, the packet waits; it is re-offered every 2 cycles (each phase v).
- Ejection:
  - A core write at edge t into VC v sets the buffer at t.
  - Delivery happens at the first edge t' > t where `polarity` = v and `pero` = 1.
  - `peso`/`pedo` are valid for exactly one cycle after t'. Minimum core-to-PE latency is 1–2 cycles, depending on phase.
- Throughput: at most one injection per cycle (alternating VCs), one drain per cycle, and one delivery per cycle.
- `peri`, `inj_valid`, `inj_data` and `ej_ready` are combinational from registers and `polarity` only. There is no combinational path from `pesi`, `inj_ready` or `pero` to any output.

## Test plan
- Reset, then idle 4 cycles -> `polarity` sequence 0,1,0,1; `peri` = 1; `peso` = 0, `pedo` = 0; both counters 0.
- Inject while `polarity` = 0 with `pedi` = 0x8000_0001_0000_0002 (VC1), `inj_ready` = 1 -> `inj_valid` = 1 the next cycle with identical data; `inj_cnt` = 1.
- Inject while `polarity` = 0 with `pedi[63]` = 0 -> packet dropped; `err_vc` = 1 and stays 1; `inj_cnt` unchanged.
- Inject VC0 with `inj_ready` held 0 for 6 cycles -> `peri` = 0 on every odd-polarity cycle; a second `pesi` on VC0 is ignored; the packet drains on the first even cycle after `inj_ready` rises.
- Core writes VC0 and VC1 packets back to back with `pero` = 0 for 6 cycles -> `ej_ready` = 2'b00; after `pero` rises, `peso` pulses twice on consecutive cycles with the correct data; `ej_cnt` = 2.
- Assert `reset` mid-ejection with a buffer full -> `peso` = 0, `ej_ready` = 2'b11, and counters 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/gold_pe_port.sv
// gold_pe_port: router-side endpoint of the PE interface. Sources the phase
// signal, buffers PE injections per VC for the router core, and buffers core
// ejections per VC for delivery back to the PE.
module gold_pe_port #(
    parameter int unsigned DW = 64,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic          polarity,
    input  logic          pesi,
    output logic          peri,
    input  logic [DW-1:0] pedi,
    output logic          peso,
    input  logic          pero,
    output logic [DW-1:0] pedo,
    output logic          inj_valid,
    input  logic          inj_ready,
    output logic [DW-1:0] inj_data,
    input  logic          ej_valid,
    input  logic [DW-1:0] ej_data,
    output logic [1:0]    ej_ready,
    output logic          err_vc,
    output logic [CW-1:0] inj_cnt,
    output logic [CW-1:0] ej_cnt
);

    logic                 pol_q;
    logic [1:0]           inj_full_q, inj_full_d;
    logic [1:0][DW-1:0]   inj_buf_q, inj_buf_d;
    logic [1:0]           ej_full_q, ej_full_d;
    logic [1:0][DW-1:0]   ej_buf_q, ej_buf_d;
    logic                 peso_q, peso_d;
    logic [DW-1:0]        pedo_q, pedo_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        inj_cnt_q, inj_cnt_d;
    logic [CW-1:0]        ej_cnt_q, ej_cnt_d;

    logic                 inj_vc;
    logic                 accept;
    logic                 vc_ok;
    logic                 drain;
    logic                 ej_vc;
    logic                 ej_wr;
    logic                 deliver;

    // Handshake decode; everything seen by the PE/core derives from registers and phase only
    always_comb begin
        inj_vc    = ~pol_q;
        peri      = ~inj_full_q[inj_vc];
        inj_valid = inj_full_q[pol_q];
        inj_data  = inj_buf_q[pol_q];
        ej_ready  = ~ej_full_q;
        accept    = pesi & peri;
        vc_ok     = (pedi[DW-1] == inj_vc);
        drain     = inj_valid & inj_ready;
        ej_vc     = ej_data[DW-1];
        ej_wr     = ej_valid & ~ej_full_q[ej_vc];
        deliver   = pero & ej_full_q[pol_q];
    end

    // Next-state for buffers, output registers, error flag and counters
    always_comb begin
        inj_full_d = inj_full_q;
        inj_buf_d  = inj_buf_q;
        ej_full_d  = ej_full_q;
        ej_buf_d   = ej_buf_q;
        peso_d     = 1'b0;
        pedo_d     = '0;
        err_d      = err_q;
        inj_cnt_d  = inj_cnt_q;
        ej_cnt_d   = ej_cnt_q;

        // Drain targets VC pol_q, accept targets VC ~pol_q: never the same entry
        if (drain) begin
            inj_full_d[pol_q] = 1'b0;
        end
        if (accept) begin
            if (vc_ok) begin
                inj_full_d[inj_vc] = 1'b1;
                inj_buf_d[inj_vc]  = pedi;
                inj_cnt_d          = inj_cnt_q + CW'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        // Write needs an empty entry and delivery a full one, so they never collide
        if (ej_wr) begin
            ej_full_d[ej_vc] = 1'b1;
            ej_buf_d[ej_vc]  = ej_data;
        end
        if (deliver) begin
            peso_d           = 1'b1;
            pedo_d           = ej_buf_q[pol_q];
            ej_full_d[pol_q] = 1'b0;
            ej_cnt_d         = ej_cnt_q + CW'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pol_q      <= 1'b0;
            inj_full_q <= '0;
            inj_buf_q  <= '0;
            ej_full_q  <= '0;
            ej_buf_q   <= '0;
            peso_q     <= 1'b0;
            pedo_q     <= '0;
            err_q      <= 1'b0;
            inj_cnt_q  <= '0;
            ej_cnt_q   <= '0;
        end else begin
            pol_q      <= ~pol_q;
            inj_full_q <= inj_full_d;
            inj_buf_q  <= inj_buf_d;
            ej_full_q  <= ej_full_d;
            ej_buf_q   <= ej_buf_d;
            peso_q     <= peso_d;
            pedo_q     <= pedo_d;
            err_q      <= err_d;
            inj_cnt_q  <= inj_cnt_d;
            ej_cnt_q   <= ej_cnt_d;
        end
    end

    // Registered outputs
    always_comb begin
        polarity = pol_q;
        peso     = peso_q;
        pedo     = pedo_q;
        err_vc   = err_q;
        inj_cnt  = inj_cnt_q;
        ej_cnt   = ej_cnt_q;
    end

endmodule

// File: tb/tb_gold_pe_port.sv
// Directed bench for gold_pe_port with scoreboard queues for core-side drains
// and PE-side deliveries.
module tb_gold_pe_port;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic          pesi;
    logic          peri;
    logic [DW-1:0] pedi;
    logic          peso;
    logic          pero;
    logic [DW-1:0] pedo;
    logic          inj_valid;
    logic          inj_ready;
    logic [DW-1:0] inj_data;
    logic          ej_valid;
    logic [DW-1:0] ej_data;
    logic [1:0]    ej_ready;
    logic          err_vc;
    logic [CW-1:0] inj_cnt;
    logic [CW-1:0] ej_cnt;

    int total = 0;
    int bad   = 0;
    logic pol_m;
    logic [DW-1:0] inj_q[$];
    logic [DW-1:0] ej_q[$];

    localparam logic [DW-1:0] PktV1  = 64'h8000_0001_0000_0002;
    localparam logic [DW-1:0] PktBad = 64'h0000_0000_0000_0055;
    localparam logic [DW-1:0] PktV0  = 64'h1234_5678_9abc_def0;
    localparam logic [DW-1:0] PktIgn = 64'h0000_0000_0000_0077;
    localparam logic [DW-1:0] PktA   = 64'h0000_00aa_0000_0001;
    localparam logic [DW-1:0] PktB   = 64'h8000_00bb_0000_0002;
    localparam logic [DW-1:0] PktC   = 64'h0000_00cc_0000_0003;
    localparam logic [DW-1:0] PktD   = 64'h0000_00dd_0000_0004;
    localparam logic [DW-1:0] PktE   = 64'h8000_00ee_0000_0005;

    gold_pe_port #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .pesi      (pesi),
        .peri      (peri),
        .pedi      (pedi),
        .peso      (peso),
        .pero      (pero),
        .pedo      (pedo),
        .inj_valid (inj_valid),
        .inj_ready (inj_ready),
        .inj_data  (inj_data),
        .ej_valid  (ej_valid),
        .ej_data   (ej_data),
        .ej_ready  (ej_ready),
        .err_vc    (err_vc),
        .inj_cnt   (inj_cnt),
        .ej_cnt    (ej_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        pol_m = ~pol_m;
    endtask

    // Scoreboard: pop on every core drain and every PE delivery
    always @(negedge clk) begin
        if (reset) begin
            if (inj_valid && inj_ready) begin
                if (inj_q.size() == 0) check("inj_unexpected", 64'(inj_data), 64'hdead);
                else check("inj_drain_data", 64'(inj_data), 64'(inj_q.pop_front()));
            end
            if (peso) begin
                if (ej_q.size() == 0) check("ej_unexpected", 64'(pedo), 64'hdead);
                else check("ej_deliver_data", 64'(pedo), 64'(ej_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; pesi = 1'b0; pedi = '0; pero = 1'b0; inj_ready = 1'b0;
        ej_valid = 1'b0; ej_data = '0; pol_m = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_polarity", 64'(polarity), 64'(0));
        check("rst_peso", 64'(peso), 64'(0));
        check("rst_pedo", 64'(pedo), 64'(0));
        check("rst_ej_ready", 64'(ej_ready), 64'(2'b11));
        check("rst_inj_valid", 64'(inj_valid), 64'(0));
        check("rst_inj_cnt", 64'(inj_cnt), 64'(0));
        check("rst_ej_cnt", 64'(ej_cnt), 64'(0));
        check("rst_err_vc", 64'(err_vc), 64'(0));

        // Release; first cycle is EVEN, then alternate
        reset = 1'b1; pol_m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("idle_polarity", 64'(polarity), 64'(pol_m));
            check("idle_peri", 64'(peri), 64'(1));
            tick();
        end

        // Inject VC1 at even phase, core ready
        inj_ready = 1'b1; pesi = 1'b1; pedi = PktV1;
        check("inj1_peri", 64'(peri), 64'(1));
        inj_q.push_back(PktV1);
        tick();
        pesi = 1'b0;
        check("inj1_valid", 64'(inj_valid), 64'(1));
        check("inj1_data", 64'(inj_data), 64'(PktV1));
        check("inj1_cnt", 64'(inj_cnt), 64'(1));
        tick();
        check("inj1_drained", 64'(inj_valid), 64'(0));

        // Wrong VC bit at even phase: dropped, sticky error
        pesi = 1'b1; pedi = PktBad;
        tick();
        pesi = 1'b0;
        check("err_set", 64'(err_vc), 64'(1));
        check("err_cnt", 64'(inj_cnt), 64'(1));
        check("err_no_valid", 64'(inj_valid), 64'(0));
        tick();
        check("err_sticky", 64'(err_vc), 64'(1));

        // Inject VC0 with core stalled; repeat pesi on VC0 must be ignored
        tick();
        inj_ready = 1'b0; pesi = 1'b1; pedi = PktV0;
        check("inj0_peri", 64'(peri), 64'(1));
        inj_q.push_back(PktV0);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (pol_m) begin
                pesi = (i == 1); pedi = PktIgn;
                check("stall_peri_odd", 64'(peri), 64'(0));
            end else begin
                pesi = 1'b0;
                check("stall_valid_even", 64'(inj_valid), 64'(1));
                check("stall_data_even", 64'(inj_data), 64'(PktV0));
            end
            tick();
        end
        pesi = 1'b0;
        check("stall_cnt", 64'(inj_cnt), 64'(2));
        tick();
        inj_ready = 1'b1;
        check("stall_odd_novalid", 64'(inj_valid), 64'(0));
        tick();
        check("stall_even_valid", 64'(inj_valid), 64'(1));
        tick();
        tick();
        check("stall_drained", 64'(inj_valid), 64'(0));

        // Ejection: VC0 then VC1 back to back with PE not ready
        ej_valid = 1'b1; ej_data = PktA;
        check("ej_ready_empty", 64'(ej_ready), 64'(2'b11));
        ej_q.push_back(PktA);
        tick();
        ej_data = PktB;
        ej_q.push_back(PktB);
        tick();
        ej_valid = 1'b0;
        check("ej_ready_full", 64'(ej_ready), 64'(2'b00));
        for (int i = 0; i < 4; i++) begin
            ej_valid = (i == 1); ej_data = PktC;
            check("ej_hold_ready", 64'(ej_ready), 64'(2'b00));
            check("ej_hold_peso", 64'(peso), 64'(0));
            tick();
        end
        ej_valid = 1'b0;
        if (pol_m) tick();
        pero = 1'b1;
        tick();
        check("ej_first_peso", 64'(peso), 64'(1));
        check("ej_first_pedo", 64'(pedo), 64'(PktA));
        check("ej_first_ready", 64'(ej_ready), 64'(2'b01));
        tick();
        pero = 1'b0;
        check("ej_second_peso", 64'(peso), 64'(1));
        check("ej_second_pedo", 64'(pedo), 64'(PktB));
        tick();
        check("ej_done_peso", 64'(peso), 64'(0));
        check("ej_done_pedo", 64'(pedo), 64'(0));
        check("ej_done_cnt", 64'(ej_cnt), 64'(2));
        check("ej_done_ready", 64'(ej_ready), 64'(2'b11));

        // Reset mid-ejection with a buffer full and peso high
        ej_valid = 1'b1; ej_data = PktD;
        ej_q.push_back(PktD);
        tick();
        ej_data = PktE;
        ej_q.push_back(PktE);
        tick();
        ej_valid = 1'b0;
        if (pol_m) tick();
        pero = 1'b1;
        tick();
        pero = 1'b0;
        check("mid_peso", 64'(peso), 64'(1));
        check("mid_ready", 64'(ej_ready), 64'(2'b01));
        #5 reset = 1'b0;
        #1;
        check("async_peso", 64'(peso), 64'(0));
        check("async_pedo", 64'(pedo), 64'(0));
        check("async_ready", 64'(ej_ready), 64'(2'b11));
        check("async_inj_cnt", 64'(inj_cnt), 64'(0));
        check("async_ej_cnt", 64'(ej_cnt), 64'(0));
        check("async_err", 64'(err_vc), 64'(0));
        check("async_polarity", 64'(polarity), 64'(0));
        ej_q.delete();

        @(posedge clk);
        #1;
        reset = 1'b1; pol_m = 1'b0;
        check("rel_polarity0", 64'(polarity), 64'(0));
        tick();
        check("rel_polarity1", 64'(polarity), 64'(1));
        check("rel_peso", 64'(peso), 64'(0));

        check("inj_q_empty", 64'(inj_q.size()), 64'(0));
        check("ej_q_empty", 64'(ej_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
